seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Four-digit multiplexed 7-segment scan driver, downstream of the custom-sequence counter stages. It latches a 16-bit hex value (four nibbles) on a load strobe and double-buffers it so a frame never tears. It time-multiplexes the digits with a programmable dwell and an anti-ghosting blank gap, and supports leading-zero blanking and per-digit decimal points. Its outputs drive the board's `display`/`control` pins directly.

## Interface
- `SCAN_DIV`, 200: clk cycles each digit is driven (legal 2..65535).
- `GAP_CYCLES`, 4: clk cycles all digits are off between digits (legal 1..255).
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low; low forces reset state immediately.
- `load` in 1: single-cycle strobe; captures `value`/`dp_in` into shadow.
- `value` in 16: nibbles [15:12]=digit3 (leftmost) … [3:0]=digit0.
- `dp_in` in 4: decimal point per digit, bit n → digit n.
- `blank_lz` in 1: leading-zero blanking enable (level).
- `enable` in 1: scan enable (level).
- `display` out 8: segments {a,b,c,d,e,f,g,dp}, active-high, registered.
- `control` out 4: digit selects, active-low, bit n → digit n, registered.
- `frame_done` out 1: one-cycle pulse at end of each frame.

## Operation
- Segment encoding, nibble→{a..g,dp=0}: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110, A=11111010, b=00111110, c=00011010, d=01111010, E=11011110, F=10001110. `display[0]` = dp bit of the active digit, ORed after encoding/blanking.
- Registers: shadow{value,dp}, active{value,dp}, pending flag, state {GAP, SHOW}, ptr[1:0], cnt[15:0].
- GAP: `control`=1111, `display`=00000000. cnt counts 0..GAP_CYCLES-1, then → SHOW, cnt=0.
- SHOW: `control` = all ones except bit ptr low; `display` = enc(active nibble ptr) | dp. cnt counts 0..SCAN_DIV-1, then → GAP, cnt=0, ptr ← ptr−1 (3→2→1→0→3).
- Scan order is digit3, 2, 1, 0. A frame is four SHOW+GAP pairs.
- Load: `load`=1 writes shadow and sets pending. A load while pending already set overwrites shadow; last write wins.
- Promotion: on the GAP→SHOW transition with ptr=3, if pending, active ← shadow and pending ← 0. The new value is used from that SHOW onward. Load and promotion in the same cycle: the new load is captured to shadow, stays pending, and the older shadow is promoted.
- Leading-zero blanking (blank_lz=1): digit n∈{3,2,1} shows segments a..g=0 if its nibble and all higher nibbles are 0. Digit0 is never blanked. dp is still shown on a blanked digit. Evaluated on active value.
- `frame_done` asserts for one cycle on the first GAP cycle after digit0's SHOW.
- `enable`=0: next edge forces state=GAP, ptr=3, cnt=0, outputs off. No frame_done. Pending is promoted immediately. Scan restarts from the leading gap when `enable` returns to 1.

## Timing
- Reset (reset=0), asynchronous: `display`=00000000, `control`=1111, `frame_done`=0. Shadow/active=0, dp=0, pending=0, state=GAP, ptr=3, cnt=0.
- After reset release with enable=1, digit3 SHOW begins at edge GAP_CYCLES. `control`=0111 is visible in the cycle after that edge.
- Frame period = 4×(SCAN_DIV+GAP_CYCLES) cycles. Refresh at 100 MHz with defaults ≈ 122 kHz per frame.
- Load-to-display latency: up to one frame period plus GAP_CYCLES. Visibility occurs only from a digit3 SHOW.
- Outputs are registered. State, ptr and output changes appear together on the same edge; there is no combinational input→output path.
- Reset asserted mid-SHOW blanks outputs immediately and discards pending.
- cnt never exceeds its terminal value. Parameter changes require re-elaboration.

## Test plan
- Reset/first frame, SCAN_DIV=4, GAP=2: load 0x1234 in cycle 0 after release. Expect 2 blank cycles, then control 0111/display 01100000 ×4, blank ×2, 1011/11011010 ×4, blank ×2, 1101/11110010 ×4, blank ×2, 1110/01100110 ×4. frame_done=1 on the next cycle.
- No tearing: active 0x1234, load 0xABCD during digit2 SHOW. The rest of that frame shows 2,3,4; the next frame shows A,b,c,d (11111010, 00111110, 00011010, 01111010).
- LZ blanking, blank_lz=1: 0x0050 gives digit3=00000000, digit2=00000000, digit1=10110110, digit0=11111100. 0x0000 blanks digits 3..1 and shows 11111100 on digit0. With blank_lz=0 all four show 11111100.
- Decimal point: value 0x0000, dp_in=0100, blank_lz=1. Digit2 shows 00000001; digit3 and digit1 show 00000000.
- Enable drop mid-digit1 SHOW: outputs off next cycle, no frame_done. On re-enable, GAP_CYCLES blank then digit3.
- Async reset pulse mid-SHOW with no clock edge: display=00000000 and control=1111 immediately. Pending is cleared and the old shadow is not shown.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit multiplexed 7-segment scan driver
//
// Latches a 16-bit hex value plus per-digit decimal points into a shadow
// buffer and promotes it to the displayed (active) copy only at the start of
// a frame, so a frame never mixes old and new digits. Digits are scanned
// 3,2,1,0 with SCAN_DIV cycles on and GAP_CYCLES all-off between digits.
//
// Ports:
//   clk        in  1   system clock, rising edge
//   reset      in  1   asynchronous, active-low
//   load       in  1   strobe: capture value/dp_in into shadow
//   value      in  16  digit3 = [15:12] ... digit0 = [3:0]
//   dp_in      in  4   decimal point, bit n -> digit n
//   blank_lz   in  1   leading-zero blanking enable
//   enable     in  1   scan enable
//   display    out 8   segments {a,b,c,d,e,f,g,dp}, active-high
//   control    out 4   digit selects, active-low, bit n -> digit n
//   frame_done out 1   one-cycle pulse on the gap following digit0
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV   = 200,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        enable,
  output logic [7:0]  display,
  output logic [3:0]  control,
  output logic        frame_done
);

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] SHOW_LAST = 16'(SCAN_DIV - 1);

  state_t      state, state_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] shadow_value, active_value, active_value_nxt;
  logic [3:0]  shadow_dp, active_dp, active_dp_nxt;
  logic        pending, pending_nxt;
  logic        promote;
  logic        frame_done_nxt;
  logic [7:0]  display_nxt;
  logic [3:0]  control_nxt;
  logic [3:0]  lz;
  logic [3:0]  nibble;
  logic [7:0]  seg;

  function automatic logic [7:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 8'b11111100;
      4'h1: enc = 8'b01100000;
      4'h2: enc = 8'b11011010;
      4'h3: enc = 8'b11110010;
      4'h4: enc = 8'b01100110;
      4'h5: enc = 8'b10110110;
      4'h6: enc = 8'b10111110;
      4'h7: enc = 8'b11100000;
      4'h8: enc = 8'b11111110;
      4'h9: enc = 8'b11110110;
      4'hA: enc = 8'b11111010;
      4'hB: enc = 8'b00111110;
      4'hC: enc = 8'b00011010;
      4'hD: enc = 8'b01111010;
      4'hE: enc = 8'b11011110;
      4'hF: enc = 8'b10001110;
    endcase
  endfunction

  // Next state, promotion and the registered output values. Outputs are
  // derived from the *next* state so they change on the same edge as
  // state/ptr, with no input-to-output combinational path.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    cnt_nxt        = cnt;
    promote        = 1'b0;
    frame_done_nxt = 1'b0;

    if (!enable) begin
      // Idle: park at the leading gap of a frame; flush any pending load
      // so it is shown as soon as scanning resumes.
      state_nxt = GAP;
      ptr_nxt   = 2'd3;
      cnt_nxt   = '0;
      promote   = pending;
    end else begin
      case (state)
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
            promote   = pending && (ptr == 2'd3);
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nxt      = GAP;
            cnt_nxt        = '0;
            ptr_nxt        = ptr - 2'd1;
            frame_done_nxt = (ptr == 2'd0);
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        default: begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      endcase
    end

    active_value_nxt = promote ? shadow_value : active_value;
    active_dp_nxt    = promote ? shadow_dp    : active_dp;

    // A load coinciding with promotion stays pending: the promoted copy is
    // the older shadow, the new one waits for the next frame.
    if (load) begin
      pending_nxt = 1'b1;
    end else if (promote) begin
      pending_nxt = 1'b0;
    end else begin
      pending_nxt = pending;
    end

    // lz[n]: nibble n and every nibble above it are zero. Digit0 never blanks.
    lz[3] = (active_value_nxt[15:12] == 4'h0);
    lz[2] = lz[3] && (active_value_nxt[11:8] == 4'h0);
    lz[1] = lz[2] && (active_value_nxt[7:4] == 4'h0);
    lz[0] = 1'b0;

    nibble = active_value_nxt[{ptr_nxt, 2'b00} +: 4];
    seg    = enc(nibble);
    if (blank_lz && lz[ptr_nxt]) begin
      seg[7:1] = 7'b0;
    end

    display_nxt = 8'h00;
    control_nxt = 4'hF;
    if (state_nxt == SHOW) begin
      control_nxt[ptr_nxt] = 1'b0;
      display_nxt          = seg | {7'b0, active_dp_nxt[ptr_nxt]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= GAP;
      ptr          <= 2'd3;
      cnt          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      active_value <= '0;
      active_dp    <= '0;
      pending      <= 1'b0;
      display      <= 8'h00;
      control      <= 4'hF;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      cnt          <= cnt_nxt;
      active_value <= active_value_nxt;
      active_dp    <= active_dp_nxt;
      pending      <= pending_nxt;
      display      <= display_nxt;
      control      <= control_nxt;
      frame_done   <= frame_done_nxt;
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard testbench for seg_scan_driver
module tb_seg_scan_driver;

  localparam int SD  = 4;
  localparam int GAP = 2;
  localparam int FRAME = 4 * (SD + GAP);

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        enable;
  logic [7:0]  display;
  logic [3:0]  control;
  logic        frame_done;

  int n_vec;
  int n_err;
  logic mon_en;
  logic [11:0] exp_q[$];

  seg_scan_driver #(.SCAN_DIV(SD), .GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .value(value),
    .dp_in(dp_in),
    .blank_lz(blank_lz),
    .enable(enable),
    .display(display),
    .control(control),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_digit(input logic [3:0] ctl, input logic [7:0] disp);
    repeat (SD) exp_q.push_back({ctl, disp});
  endtask

  task automatic push_frame(input logic [7:0] d3, input logic [7:0] d2,
                            input logic [7:0] d1, input logic [7:0] d0);
    push_digit(4'b0111, d3);
    push_digit(4'b1011, d2);
    push_digit(4'b1101, d1);
    push_digit(4'b1110, d0);
  endtask

  // Load a new value while scanning is disabled; the disabled edge promotes it.
  task automatic set_active(input logic [15:0] v, input logic [3:0] dp);
    enable = 1'b0;
    load   = 1'b1;
    value  = v;
    dp_in  = dp;
    tick();
    load = 1'b0;
    tick();
  endtask

  // Scan nframes starting from the leading gap; optional load strobe issued
  // after cycle load_at (0 = before the first edge, negative = none).
  task automatic run_frames(input int nframes, input int load_at,
                            input logic [15:0] lval, input logic [3:0] ldp);
    enable = 1'b1;
    mon_en = 1'b1;
    if (load_at == 0) begin
      load  = 1'b1;
      value = lval;
      dp_in = ldp;
    end
    for (int c = 1; c <= FRAME * nframes; c++) begin
      tick();
      if (c == load_at + 1) begin
        load = 1'b0;
      end else if (c == load_at) begin
        load  = 1'b1;
        value = lval;
        dp_in = ldp;
      end
      if (c == 1) check("lead_gap_ctl", 32'(control), 32'hF);
      if (c == GAP) check("first_show_ctl", 32'(control), 32'h7);
      check("frame_done", 32'(frame_done), 32'((c % FRAME) == 0));
    end
    enable = 1'b0;
    tick();
    check("frame_done_after_stop", 32'(frame_done), 32'h0);
    mon_en = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  // Monitor: every displayed digit cycle consumes one scoreboard entry; gap
  // cycles must be dark.
  always @(negedge clk) begin
    if (mon_en) begin
      if (control != 4'hF) begin
        if (exp_q.size() == 0) begin
          check("unexpected_digit", 32'({control, display}), 32'hFFF);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("digit", 32'({control, display}), 32'(e));
        end
      end else begin
        check("gap_dark", 32'(display), 32'h0);
      end
    end
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    mon_en   = 1'b0;
    reset    = 1'b0;
    load     = 1'b0;
    value    = 16'h0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    enable   = 1'b1;
    repeat (3) tick();
    check("rst_display", 32'(display), 32'h0);
    check("rst_control", 32'(control), 32'hF);
    check("rst_frame_done", 32'(frame_done), 32'h0);

    // First frame after release, load in cycle 0
    reset = 1'b1;
    push_frame(8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110);
    run_frames(1, 0, 16'h1234, 4'h0);

    // No tearing: load ABCD during digit2 of the first frame
    push_frame(8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110);
    push_frame(8'b11111010, 8'b00111110, 8'b00011010, 8'b01111010);
    run_frames(2, 9, 16'hABCD, 4'h0);

    // Leading-zero blanking
    blank_lz = 1'b1;
    set_active(16'h0050, 4'h0);
    push_frame(8'h00, 8'h00, 8'b10110110, 8'b11111100);
    run_frames(1, -5, 16'h0, 4'h0);
    set_active(16'h0000, 4'h0);
    push_frame(8'h00, 8'h00, 8'h00, 8'b11111100);
    run_frames(1, -5, 16'h0, 4'h0);
    blank_lz = 1'b0;
    push_frame(8'b11111100, 8'b11111100, 8'b11111100, 8'b11111100);
    run_frames(1, -5, 16'h0, 4'h0);

    // Decimal point on a blanked digit
    blank_lz = 1'b1;
    set_active(16'h0000, 4'b0100);
    push_frame(8'h00, 8'h01, 8'h00, 8'b11111100);
    run_frames(1, -5, 16'h0, 4'h0);

    // Enable drop mid digit1
    blank_lz = 1'b0;
    set_active(16'h1234, 4'h0);
    push_digit(4'b0111, 8'b01100000);
    push_digit(4'b1011, 8'b11011010);
    exp_q.push_back({4'b1101, 8'b11110010});
    exp_q.push_back({4'b1101, 8'b11110010});
    enable = 1'b1;
    mon_en = 1'b1;
    for (int c = 1; c <= 15; c++) tick();
    enable = 1'b0;
    tick();
    check("drop_control", 32'(control), 32'hF);
    check("drop_display", 32'(display), 32'h0);
    check("drop_frame_done", 32'(frame_done), 32'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_frame_done", 32'(frame_done), 32'h0);
    end
    mon_en = 1'b0;
    check("drop_queue_drained", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    push_frame(8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110);
    run_frames(1, -5, 16'h0, 4'h0);

    // Async reset mid-SHOW with a pending load
    push_digit(4'b0111, 8'b01100000);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    enable = 1'b1;
    mon_en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 3) begin
        load  = 1'b1;
        value = 16'h5678;
        dp_in = 4'hF;
      end else if (c == 4) begin
        load = 1'b0;
      end
    end
    #2;
    reset = 1'b0;
    #1;
    check("async_display", 32'(display), 32'h0);
    check("async_control", 32'(control), 32'hF);
    check("async_frame_done", 32'(frame_done), 32'h0);
    mon_en = 1'b0;
    enable = 1'b0;
    check("async_queue_drained", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    push_frame(8'b11111100, 8'b11111100, 8'b11111100, 8'b11111100);
    run_frames(1, -5, 16'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
